// File: rtl/lcd_pkg.sv
// Shared LCD constants and pixel payload type, also used by the LCD controller.
package lcd_pkg;

   localparam int unsigned PIXEL_W   = 24;
   localparam int unsigned H_RES_DEF = 480;
   localparam int unsigned V_RES_DEF = 272;
   localparam int unsigned DEPTH_DEF = 16;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

endpackage

// File: rtl/lcd_pixel_streamer_if.sv
// Pixel stream bundle: writer-side push handshake plus LCD-side pop handshake and markers.
interface lcd_pixel_streamer_if;
   import lcd_pkg::*;

   pixel_t in_data;
   logic   in_valid;
   logic   in_ready;
   pixel_t pixel;
   logic   valid;
   logic   ready;
   logic   sof;
   logic   eol;
   logic   eof;

   modport master (
      output in_data, in_valid, ready,
      input  in_ready, pixel, valid, sof, eol, eof
   );

   modport slave (
      input  in_data, in_valid, ready,
      output in_ready, pixel, valid, sof, eol, eof
   );

endinterface

// File: rtl/lcd_pixel_fifo.sv
// First-word-fall-through pixel FIFO: storage, pointers and occupancy.
module lcd_pixel_fifo
   import lcd_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  pixel_t                   wdata,
   output pixel_t                   rdata,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   pixel_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // Pointer and occupancy tracking; clr drops any push/pop that cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(push) - LW'(pop);
      end
   end

   // Storage write; contents need no reset since level gates visibility.
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/lcd_pixel_streamer.sv
// Buffers writer pixels and streams them to the LCD with frame position markers and error flags.
module lcd_pixel_streamer
   import lcd_pkg::*;
#(
   parameter int unsigned H_RES = H_RES_DEF,
   parameter int unsigned V_RES = V_RES_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   lcd_pixel_streamer_if.slave      bus,
   input  logic                     frame_sync,
   input  logic                     flush,
   input  logic                     clear_status,
   output logic                     underrun,
   output logic                     misalign,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;

   logic          run;
   logic          push;
   logic          pop;
   logic          not_empty;
   pixel_t        head;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [XW-1:0] x_pop;
   logic [YW-1:0] y_pop;
   logic          underrun_set;
   logic          misalign_set;

   lcd_pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push),
      .pop   (pop),
      .wdata (bus.in_data),
      .rdata (head),
      .level (level)
   );

   // Handshakes: flush blocks both sides; no push while full even if popping.
   assign not_empty    = (level != '0);
   assign bus.valid    = not_empty;
   assign bus.pixel    = not_empty ? head : '0;
   assign bus.in_ready = run && (level < LW'(DEPTH)) && !flush;
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = not_empty && bus.ready && !flush;

   // Frame markers decoded from the position of the head pixel.
   assign bus.sof = (x == '0) && (y == '0);
   assign bus.eol = (x == XW'(H_RES - 1));
   assign bus.eof = bus.eol && (y == YW'(V_RES - 1));

   // Position after this cycle's pop.
   always_comb begin
      x_pop = x;
      y_pop = y;
      if (pop) begin
         if (x == XW'(H_RES - 1)) begin
            x_pop = '0;
            y_pop = (y == YW'(V_RES - 1)) ? '0 : y + YW'(1);
         end else begin
            x_pop = x + XW'(1);
         end
      end
   end

   assign underrun_set = bus.ready && !not_empty && ((x != '0) || (y != '0));
   assign misalign_set = !flush && frame_sync && ((x_pop != '0) || (y_pop != '0));

   // Position counters: flush beats frame_sync beats pop advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run <= 1'b0;
         x   <= '0;
         y   <= '0;
      end else begin
         run <= 1'b1;
         if (flush || frame_sync) begin
            x <= '0;
            y <= '0;
         end else begin
            x <= x_pop;
            y <= y_pop;
         end
      end
   end

   // Sticky error flags; a set condition outranks clear_status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         underrun <= 1'b0;
         misalign <= 1'b0;
      end else begin
         if (underrun_set)      underrun <= 1'b1;
         else if (clear_status) underrun <= 1'b0;
         if (misalign_set)      misalign <= 1'b1;
         else if (clear_status) misalign <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lcd_pixel_streamer.sv
// Directed checks of the pixel streamer with a 4x2 frame and a 16-deep FIFO.
module tb_lcd_pixel_streamer;
   import lcd_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned LW    = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_sync = 1'b0;
   logic          flush = 1'b0;
   logic          clear_status = 1'b0;
   logic          underrun;
   logic          misalign;
   logic [LW-1:0] level;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   lcd_pixel_streamer_if bus ();

   lcd_pixel_streamer #(.H_RES(4), .V_RES(2), .DEPTH(DEPTH)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .frame_sync   (frame_sync),
      .flush        (flush),
      .clear_status (clear_status),
      .underrun     (underrun),
      .misalign     (misalign),
      .level        (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic push_n(input int n, input logic [23:0] base);
      for (int i = 1; i <= n; i++) begin
         bus.in_data  = base + 24'(i);
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.ready    = 1'b0;

      // Reset state
      #1 rst = 1'b0;
      #2;
      chk("rst_valid",    32'(bus.valid),    32'd0);
      chk("rst_level",    32'(level),        32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_pixel",    32'(bus.pixel),    32'd0);
      chk("rst_underrun", 32'(underrun),     32'd0);
      chk("rst_misalign", 32'(misalign),     32'd0);
      tick();
      rst = 1'b1;
      #1;
      chk("in_ready_before_edge", 32'(bus.in_ready), 32'd0);
      tick();
      chk("in_ready_after_edge",  32'(bus.in_ready), 32'd1);

      // Four pixels buffered, then drained in order
      bus.in_data  = 24'h000001;
      bus.in_valid = 1'b1;
      tick();
      chk("fwft_valid", 32'(bus.valid), 32'd1);
      chk("fwft_pixel", 32'(bus.pixel), 32'h000001);
      for (int i = 2; i <= 4; i++) begin
         bus.in_data = 24'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("fill4_level", 32'(level), 32'd4);
      chk("fill4_sof",   32'(bus.sof), 32'd1);
      tick();
      chk("hold_pixel",  32'(bus.pixel), 32'h000001);
      bus.ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("drain_pixel", 32'(bus.pixel), 32'(k));
         chk("drain_sof",   32'(bus.sof),   32'(k == 1));
         chk("drain_eol",   32'(bus.eol),   32'(k == 4));
         tick();
      end
      bus.ready = 1'b0;
      chk("drain_level", 32'(level),     32'd0);
      chk("drain_valid", 32'(bus.valid), 32'd0);
      do_flush();

      // Full FIFO back-pressure
      push_n(16, 24'h0000FF);
      chk("full_level",    32'(level),        32'd16);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_data  = 24'h000BAD;
      bus.in_valid = 1'b1;
      tick();
      chk("full_ignore",   32'(level),        32'd16);
      bus.ready = 1'b1;
      tick();
      chk("full_pop_level",    32'(level),        32'd15);
      chk("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      bus.ready    = 1'b0;
      chk("full_pop_head", 32'(bus.pixel), 32'h000101);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      flush = 1'b0;
      chk("flush_level", 32'(level),   32'd0);
      chk("flush_sof",   32'(bus.sof), 32'd1);

      // Full 4x2 frame plus first pixel of the next
      push_n(9, 24'h000200);
      bus.ready = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         chk("frame_pixel", 32'(bus.pixel), 32'h200 + 32'(k));
         chk("frame_sof",   32'(bus.sof),   32'(k == 1 || k == 9));
         chk("frame_eol",   32'(bus.eol),   32'(k == 4 || k == 8));
         chk("frame_eof",   32'(bus.eof),   32'(k == 8));
         tick();
      end
      bus.ready = 1'b0;
      do_flush();

      // Mid-frame starvation
      bus.ready = 1'b1;
      push_n(3, 24'h000300);
      chk("urun_early", 32'(underrun), 32'd0);
      tick();
      chk("urun_last_pop", 32'(underrun), 32'd0);
      chk("urun_empty",    32'(level),    32'd0);
      tick();
      chk("urun_set", 32'(underrun), 32'd1);
      bus.ready = 1'b0;
      tick();
      tick();
      chk("urun_sticky", 32'(underrun), 32'd1);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      chk("urun_clear", 32'(underrun), 32'd0);
      bus.ready    = 1'b1;
      clear_status = 1'b1;
      tick();
      chk("urun_set_wins", 32'(underrun), 32'd1);
      bus.ready = 1'b0;
      tick();
      clear_status = 1'b0;
      chk("urun_clear2", 32'(underrun), 32'd0);
      do_flush();

      // frame_sync mid-frame and at origin
      push_n(8, 24'h000300);
      bus.ready = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      bus.ready  = 1'b0;
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      chk("mis_set",   32'(misalign),  32'd1);
      chk("mis_sof",   32'(bus.sof),   32'd1);
      chk("mis_pixel", 32'(bus.pixel), 32'h000306);
      chk("mis_level", 32'(level),     32'd3);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      chk("mis_clear", 32'(misalign), 32'd0);
      do_flush();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
      chk("mis_origin", 32'(misalign), 32'd0);

      // Asynchronous reset mid-frame with buffered pixels
      push_n(9, 24'h000400);
      bus.ready = 1'b1;
      tick();
      tick();
      bus.ready = 1'b0;
      chk("pre_rst_level", 32'(level), 32'd7);
      #2 rst = 1'b0;
      #1;
      chk("arst_valid",    32'(bus.valid),    32'd0);
      chk("arst_level",    32'(level),        32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("arst_sof",      32'(bus.sof),      32'd1);
      rst = 1'b1;
      tick();
      chk("arst_release_in_ready", 32'(bus.in_ready), 32'd1);
      chk("arst_discard",          32'(bus.valid),    32'd0);

      // Flush with simultaneous push and pop
      push_n(3, 24'h000500);
      bus.in_data  = 24'h000999;
      bus.in_valid = 1'b1;
      bus.ready    = 1'b1;
      flush        = 1'b1;
      tick();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      bus.ready    = 1'b0;
      chk("flush_pp_level", 32'(level),     32'd0);
      chk("flush_pp_valid", 32'(bus.valid), 32'd0);
      chk("flush_pp_sof",   32'(bus.sof),   32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lcd_pixel_streamer.md
LCD_PIXEL_STREAMER -- requirements
Module: lcd_pixel_streamer

Interface
REQ-001 Parameter: H_RES, 480, pixels per line.
REQ-002 Parameter: V_RES, 272, lines per frame.
REQ-003 Parameter: DEPTH, 16, FIFO entries (power of two, >=4).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_data  in  24  RGB888 pixel from the Nios-side writer.
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_ready  out  1  FIFO can accept; push = in_valid && in_ready.
REQ-009 pixel  out  24  pixel to the LCD controller.
REQ-010 valid  out  1  pixel valid.
REQ-011 ready  in  1  LCD controller accepts; pop = valid && ready.
REQ-012 sof / eol / eof  out  1 each  current pixel is first of frame / last of line / last of frame.
REQ-013 frame_sync  in  1  one-cycle pulse from the LCD controller at frame start.
REQ-014 flush  in  1  synchronous clear of FIFO and position counters.
REQ-015 clear_status  in  1  clears sticky flags.
REQ-016 underrun, misalign  out  1 each  sticky error flags.
REQ-017 level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 FIFO SHALL be first-word-fall-through: pixel/valid reflect head entry; push into empty FIFO visible on valid the next cycle (latency 1).
REQ-019 in_ready SHALL equal (level < DEPTH) and flush low; no push-on-pop when full (in_ready stays 0 in a full cycle even if pop occurs).
REQ-020 Simultaneous push and pop when 0 < level < DEPTH: level unchanged, order preserved.
REQ-021 Position counters x (0..H_RES-1), y (0..V_RES-1) SHALL advance only on pop; x wraps to 0 and increments y; y wraps to 0 after eof.
REQ-022 sof = (x==0 && y==0); eol = (x==H_RES-1); eof = eol && (y==V_RES-1); all combinational from counters, meaningful when valid.
REQ-023 pixel SHALL hold stable while valid && !ready.
REQ-024 underrun SHALL set when ready && !valid && (x!=0 || y!=0) (mid-frame starvation).
REQ-025 On frame_sync: if counters (after this cycle's pop) are not (0,0), misalign SHALL set and x,y SHALL be forced to 0; FIFO contents untouched.
REQ-026 flush SHALL empty the FIFO, zero x,y, drop any push/pop that cycle; priority flush > frame_sync > pop advance.
REQ-027 clear_status clears underrun/misalign; a set condition in the same cycle wins.

Reset
REQ-028 Asserting rst SHALL immediately (asynchronously) clear FIFO pointers, level=0, valid=0, in_ready=0, x=y=0, underrun=misalign=0; pixel=0.
REQ-029 in_ready SHALL go 1 on the first clock edge after rst deasserts; reset mid-frame discards all buffered pixels.

Structure
REQ-030 Shared package lcd_pkg SHALL hold PIXEL_W=24 and default H_RES/V_RES constants, reused by the LCD controller.
REQ-031 FIFO SHALL be a sub-module lcd_pixel_fifo (storage, pointers, level); counters, flags and sync logic stay in the top.

Verification
REQ-032 Push 0x000001..0x000004 with ready=0, then ready=1 -> pixels pop in order, level 4->0, sof on 0x000001.
REQ-033 Fill to DEPTH -> in_ready=0 at level 16; extra in_valid ignored; one pop -> in_ready=1 next cycle.
REQ-034 Stream H_RES*V_RES pixels with H_RES=4,V_RES=2 -> eol at x=3, eof on pixel 8, sof again on pixel 9.
REQ-035 Stop pushes after pixel 3 with ready=1 -> underrun=1 and stays 1 until clear_status.
REQ-036 frame_sync after 5 pops (H_RES=4) -> misalign=1, next pixel has sof=1; frame_sync at x=y=0 -> misalign stays 0.
REQ-037 rst low with level=7 mid-frame -> valid=0, level=0 immediately; flush with push+pop same cycle -> level=0, x=y=0.
